sd_otf_converter: RTL and testbench
===================================

// Module: sd_otf_converter
// PURPOSE
//  Reverse side of the carry-save/online datapath: consumes the MSB-first radix-2 signed-digit
//  stream produced by online operators (digit selection on Ws/Wc) and returns a conventional
//  two's-complement word via on-the-fly conversion (Q/QM registers), no carry-propagate adder.
//  Sits at the output of an online multiplier/adder recurrence; one digit per accepted cycle.
// PARAMETERS
//  WL   3   number of fractional digits per operand (= Stage); result is WL+1 bits
// PORTS
//  clk           in   1     system clock, rising edge
//  nReset        in   1     asynchronous active-low reset
//  start         in   1     pulse: clear converter, begin new WL-digit conversion
//  digit_valid   in   1     digit on `digit` is presented this cycle
//  digit         in   2     signed digit: 2'b00=0, 2'b01=+1, 2'b11=-1, 2'b10=illegal
//  digit_ready   out  1     converter accepts a digit this cycle (high only in CONV)
//  result        out  WL+1  two's-complement value*2^WL (1 integer/sign bit + WL fraction bits)
//  result_valid  out  1     result complete and stable
//  result_ready  in   1     consumer takes result; releases DONE
//  digit_err     out  1     sticky illegal-digit flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, nReset=0): state=IDLE, Q=0, QM=all ones, count=0, result=0, result_valid=0,
//    digit_ready=0, digit_err=0. Reset mid-conversion aborts; partial digits are discarded.
//  - FSM: IDLE -start-> CONV; CONV -WL-th accepted digit-> DONE; DONE -result_ready-> IDLE.
//    start in any state: Q=0, QM=all ones, count=0, digit_err=0, result_valid=0, go CONV.
//  - Accept = digit_valid & digit_ready. digit_valid in IDLE/DONE is ignored.
//  - start and digit_valid in same cycle: start wins, digit dropped.
//  - Per accepted digit q (registers WL+1 bits, shift-left-append, result = Q):
//      q=+1: Q<={Q,1}  QM<={Q,0};  q=0: Q<={Q,0}  QM<={QM,1};  q=-1: Q<={QM,1}  QM<={QM,0}
//    Invariant QM = Q - 1 (mod 2^(WL+1)) after every update; count increments by 1.
//  - Latency: result_valid rises the clock edge that accepts digit WL; result equals Q then
//    and holds until next start. digit_ready is 0 in that same cycle after the edge.
//  - Range: value in [-(1-2^-WL), 1-2^-WL]; always fits WL+1 bits, no overflow possible.
//  - Illegal 2'b10 is treated as digit 0 (still counted) in all builds.
//  - DONE with result_ready=1 and start=1: start wins (new conversion, result_valid=0).
// CONFIGURATION
//  - OTFC_DIGIT_CHK_EN defined: accepting digit 2'b10 sets digit_err (sticky until start or
//    reset); digit_err is registered, rises the edge after the illegal digit is accepted.
//  - Not defined: digit_err tied to 0, no check logic synthesised.
// STRUCTURE
//  - Shared package online_pkg: digit encodings DIG_ZERO/DIG_POS/DIG_NEG/DIG_BAD, FSM state
//    encodings ST_IDLE/ST_CONV/ST_DONE, common width helper for count (clog2(WL+1)).
//  - One sub-module otfc_append: combinational next-Q/next-QM from (Q, QM, digit); top holds
//    FSM, counter, registers, handshake.
// TESTING (WL=3, clock period 10 ns, nReset released at 100 ns)
//  - start; digits +1,0,-1 -> result=4'b0011 (+0.375), result_valid after 3rd accept.
//  - start; digits -1,+1,+1 -> result=4'b1111 (-0.125).
//  - start; +1,+1,+1 -> 4'b0111; start; -1,-1,-1 -> 4'b1001; start; 0,0,0 -> 4'b0000.
//  - digit_valid gaps (valid 1,0,1,0,1) -> same result as back-to-back; start+digit_valid
//    same cycle -> digit dropped, count stays 0.
//  - nReset low after 2 digits -> all outputs 0 immediately; new start yields correct result.
//  - OTFC_DIGIT_CHK_EN: digits +1,2'b10,+1 -> result=4'b0101, digit_err=1; cleared by start.

Source files
------------

// File: rtl/online_pkg.sv
// Shared definitions for the online-arithmetic datapath: signed-digit encodings,
// converter FSM states and the counter width helper.
package online_pkg;

  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_POS  = 2'b01,
    DIG_BAD  = 2'b10,
    DIG_NEG  = 2'b11
  } digit_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed for a digit counter that must reach wl.
  function automatic int unsigned cnt_width(input int unsigned wl);
    return (wl == 0) ? 1 : $clog2(wl + 1);
  endfunction

endpackage

// File: rtl/otfc_append.sv
// On-the-fly conversion step: next Q/QM from the current pair and one signed digit.
// Illegal digit encodings are treated as zero.
module otfc_append
  import online_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  always_comb begin
    q_next  = {q[W-2:0], 1'b0};
    qm_next = {qm[W-2:0], 1'b1};
    case (digit)
      DIG_POS: begin
        q_next  = {q[W-2:0], 1'b1};
        qm_next = {q[W-2:0], 1'b0};
      end
      DIG_NEG: begin
        q_next  = {qm[W-2:0], 1'b1};
        qm_next = {qm[W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sd_otf_converter.sv
// MSB-first radix-2 signed-digit to two's-complement converter (Q/QM on-the-fly).
// Optional build macro OTFC_DIGIT_CHK_EN enables the sticky illegal-digit flag.
module sd_otf_converter
  import online_pkg::*;
#(
  parameter int unsigned WL = 3
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          start,
  input  logic          digit_valid,
  input  logic [1:0]    digit,
  output logic          digit_ready,
  output logic [WL:0]   result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          digit_err
);

  localparam int unsigned W  = WL + 1;
  localparam int unsigned CW = cnt_width(WL);

  state_e          state, state_next;
  logic [W-1:0]    q_reg, qm_reg, q_next, qm_next;
  logic [CW-1:0]   count;
  logic            accept;
  logic            last_digit;

  // start has priority: a digit presented alongside it is dropped
  assign accept     = digit_valid & digit_ready & ~start;
  assign last_digit = (count == CW'(WL - 1));
  assign result     = q_reg;

  otfc_append #(.W(W)) u_append (
    .q       (q_reg),
    .qm      (qm_reg),
    .digit   (digit),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    digit_ready  = 1'b0;
    result_valid = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_CONV: begin
        digit_ready = 1'b1;
        if (accept && last_digit) state_next = ST_DONE;
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (start) state_next = ST_CONV;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      q_reg  <= '0;
      qm_reg <= '1;
      count  <= '0;
    end else if (start) begin
      q_reg  <= '0;
      qm_reg <= '1;
      count  <= '0;
    end else if (accept) begin
      q_reg  <= q_next;
      qm_reg <= qm_next;
      count  <= count + CW'(1);
    end
  end

`ifdef OTFC_DIGIT_CHK_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)                             digit_err <= 1'b0;
    else if (start)                          digit_err <= 1'b0;
    else if (accept && (digit == DIG_BAD))   digit_err <= 1'b1;
  end
`else
  assign digit_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_otf_converter.sv
// Self-checking bench for sd_otf_converter: directed and randomized conversions
// compared against a weighted-sum reference value.
module tb_sd_otf_converter;

  localparam int unsigned WL = 3;
  localparam int unsigned W  = WL + 1;
`ifdef OTFC_DIGIT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  logic         start = 1'b0;
  logic         digit_valid = 1'b0;
  logic [1:0]   digit = 2'b00;
  logic         result_ready = 1'b0;
  logic         digit_ready;
  logic [W-1:0] result;
  logic         result_valid;
  logic         digit_err;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sd_otf_converter #(.WL(WL)) dut (
    .clk          (clk),
    .nReset       (nReset),
    .start        (start),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .digit_ready  (digit_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .digit_err    (digit_err)
  );

  // Reference: value*2^WL = sum of d_i * 2^(WL-1-i), taken modulo 2^(WL+1).
  function automatic logic [W-1:0] model_result(input logic [2*WL-1:0] ds, input int n);
    int v = 0;
    for (int i = 0; i < n; i++) begin
      logic [1:0] d = ds[2*i +: 2];
      if (d == 2'b01)      v += (1 << (WL - 1 - i));
      else if (d == 2'b11) v -= (1 << (WL - 1 - i));
    end
    return W'(v);
  endfunction

  function automatic bit model_err(input logic [2*WL-1:0] ds, input int n);
    bit bad = 1'b0;
    for (int i = 0; i < n; i++) if (ds[2*i +: 2] == 2'b10) bad = 1'b1;
    return bad & CHK;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_digit(input logic [1:0] d);
    int n = 0;
    while (!digit_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (digit_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_timeout: digit_ready=%b required 1", digit_ready);
    end
    digit_valid = 1'b1;
    digit = d;
    @(negedge clk);
    digit_valid = 1'b0;
    digit = 2'($urandom);
  endtask

  task automatic run_conv(input logic [2*WL-1:0] ds, input bit gaps, input string name);
    logic [W-1:0] exp_r;
    do_start();
    for (int i = 0; i < WL; i++) begin
      if (gaps && i > 0) @(negedge clk);
      send_digit(ds[2*i +: 2]);
      compared++;
      if (digit_err !== model_err(ds, i + 1)) begin
        mismatched++;
        $display("FAIL %s err_d%0d: digit_err=%b required %b", name, i, digit_err, model_err(ds, i + 1));
      end
      if (i < WL - 1) begin
        compared++;
        if (result_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL %s early_valid_d%0d: result_valid=%b required 0", name, i, result_valid);
        end
      end
    end
    exp_r = model_result(ds, WL);
    compared++;
    if (result_valid !== 1'b1 || result !== exp_r || digit_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL %s done: valid=%b result=%b ready=%b required valid=1 result=%b ready=0",
               name, result_valid, result, digit_ready, exp_r);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    compared++;
    if (result_valid !== 1'b0 || result !== exp_r) begin
      mismatched++;
      $display("FAIL %s release: valid=%b result=%b required valid=0 result=%b",
               name, result_valid, result, exp_r);
    end
  endtask

  task automatic test_reset();
    #50;
    compared++;
    if (result !== '0 || result_valid !== 1'b0 || digit_ready !== 1'b0 || digit_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: result=%b valid=%b ready=%b err=%b required all 0",
               result, result_valid, digit_ready, digit_err);
    end
    #50;
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_conv({2'b11, 2'b00, 2'b01}, 1'b0, "p0n");
    run_conv({2'b01, 2'b01, 2'b11}, 1'b0, "npp");
    run_conv({2'b01, 2'b01, 2'b01}, 1'b0, "ppp");
    run_conv({2'b11, 2'b11, 2'b11}, 1'b0, "nnn");
    run_conv({2'b00, 2'b00, 2'b00}, 1'b0, "zzz");
  endtask

  task automatic test_gaps();
    run_conv({2'b11, 2'b00, 2'b01}, 1'b1, "gaps");
  endtask

  task automatic test_start_collision();
    do_start();
    send_digit(2'b01);
    start = 1'b1;
    digit_valid = 1'b1;
    digit = 2'b01;
    @(negedge clk);
    start = 1'b0;
    digit_valid = 1'b0;
    send_digit(2'b11);
    send_digit(2'b00);
    compared++;
    if (result_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL collide_count: result_valid=%b required 0", result_valid);
    end
    send_digit(2'b11);
    compared++;
    if (result_valid !== 1'b1 || result !== 4'b1011) begin
      mismatched++;
      $display("FAIL collide_result: valid=%b result=%b required valid=1 result=1011", result_valid, result);
    end
  endtask

  task automatic test_done_start();
    do_start();
    for (int i = 0; i < WL; i++) send_digit(2'b01);
    start = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    result_ready = 1'b0;
    compared++;
    if (result_valid !== 1'b0 || digit_ready !== 1'b1 || result !== '0) begin
      mismatched++;
      $display("FAIL done_start: valid=%b ready=%b result=%b required 0 1 0000",
               result_valid, digit_ready, result);
    end
    send_digit(2'b00);
    send_digit(2'b00);
    send_digit(2'b11);
    compared++;
    if (result_valid !== 1'b1 || result !== 4'b1111) begin
      mismatched++;
      $display("FAIL done_start_result: valid=%b result=%b required 1 1111", result_valid, result);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset_midway();
    do_start();
    send_digit(2'b01);
    send_digit(2'b01);
    nReset = 1'b0;
    #1;
    compared++;
    if (result !== '0 || result_valid !== 1'b0 || digit_ready !== 1'b0 || digit_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid: result=%b valid=%b ready=%b err=%b required all 0",
               result, result_valid, digit_ready, digit_err);
    end
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
    run_conv({2'b01, 2'b11, 2'b01}, 1'b0, "after_reset");
  endtask

  task automatic test_illegal();
    run_conv({2'b01, 2'b10, 2'b01}, 1'b0, "illegal");
    compared++;
    if (result !== 4'b0101) begin
      mismatched++;
      $display("FAIL illegal_value: result=%b required 0101", result);
    end
    do_start();
    compared++;
    if (digit_err !== 1'b0) begin
      mismatched++;
      $display("FAIL illegal_clear: digit_err=%b required 0", digit_err);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 25; k++) begin
      logic [2*WL-1:0] ds;
      ds = (2*WL)'($urandom);
      run_conv(ds, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_start_collision();
    test_done_start();
    test_reset_midway();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
